exec_mem_stage: RTL and testbench

- Execute/memory/writeback slice of the 8-bit single-cycle teaching processor.
- Decodes the 3-bit opcode into control signals and performs the ALU operation.
- Reads and writes the 256x8 data memory and produces the register-file writeback value.
- Sits between the instruction decoder and register file; jump target handling stays in the program counter.

---
 rtl/exec_mem_stage_pkg.sv | 57 +++++
 rtl/exec_mem_stage_if.sv | 38 +++
 rtl/exec_mem_stage_alu_core.sv | 32 +++
 rtl/exec_mem_stage.sv | 84 ++++++++
 tb/tb_exec_mem_stage.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/exec_mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// exec_mem_stage_pkg
// Shared constants and types for the execute/memory/writeback slice of the
// 8-bit teaching processor: datapath width, memory depth, opcode encodings,
// ALU operation encodings and the decoded control bundle.
// ----------------------------------------------------------------------------
package exec_mem_stage_pkg;

  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 256;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);

  // Instruction opcodes (instruction bits [7:5])
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_J    = 3'b111;

  // ALU operation codes; any unlisted code produces zero
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_ZERO = 3'b111;

  // Decoded control bundle for one instruction
  typedef struct packed {
    logic [2:0] alu_op;
    logic       jump;
    logic       mem_write;
    logic       alu_src;
    logic       wb_sel;
    logic       reg_write;
  } ctrl_t;

  // Build a control bundle from its fields in table order
  function automatic ctrl_t make_ctrl(input logic [2:0] alu_op,
                                      input logic       jump,
                                      input logic       mem_write,
                                      input logic       alu_src,
                                      input logic       wb_sel,
                                      input logic       reg_write);
    ctrl_t c;
    c.alu_op    = alu_op;
    c.jump      = jump;
    c.mem_write = mem_write;
    c.alu_src   = alu_src;
    c.wb_sel    = wb_sel;
    c.reg_write = reg_write;
    return c;
  endfunction

endpackage

// File: rtl/exec_mem_stage_if.sv
// ----------------------------------------------------------------------------
// exec_mem_stage_if
// Bundles the operand inputs and the control/datapath outputs of the
// execute/memory stage.
//   master : decoder/register-file side (drives opcode and operands)
//   slave  : the stage itself (drives control, ALU, memory and writeback)
// ----------------------------------------------------------------------------
interface exec_mem_stage_if;
  import exec_mem_stage_pkg::*;

  logic [2:0]        opcode;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm_ext;

  logic              jump;
  logic              reg_write;
  logic              mem_write;
  logic              alu_src;
  logic              wb_sel;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] writeback;

  modport master (
    output opcode, rs_data, rt_data, imm_ext,
    input  jump, reg_write, mem_write, alu_src, wb_sel, alu_op,
           alu_result, read_data, writeback
  );

  modport slave (
    input  opcode, rs_data, rt_data, imm_ext,
    output jump, reg_write, mem_write, alu_src, wb_sel, alu_op,
           alu_result, read_data, writeback
  );

endinterface

// File: rtl/exec_mem_stage_alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
// Purely combinational 8-bit ALU. ADD/SUB wrap modulo 2^DATA_W with no flags.
// Ports:
//   i_alu_op : operation code (ALU_* constants)
//   i_a      : operand A
//   i_b      : operand B
//   o_result : operation result; zero for ALU_ZERO and any unlisted code
// ----------------------------------------------------------------------------
module alu_core
  import exec_mem_stage_pkg::*;
(
  input  logic [2:0]        i_alu_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result
);

  // Select the operation; unknown codes fall to a zero result
  always_comb begin
    o_result = {DATA_W{1'b0}};
    case (i_alu_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_ZERO: o_result = {DATA_W{1'b0}};
      default:  o_result = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/exec_mem_stage.sv
// ----------------------------------------------------------------------------
// exec_mem_stage
// Execute/memory/writeback slice of the 8-bit single-cycle processor.
// Decodes the opcode into control, runs the ALU, accesses the 256x8 data
// memory and forms the register-file writeback value. Nothing but the memory
// array is stateful; every output follows its inputs combinationally.
// Ports:
//   i_clock : system clock, memory updates on the rising edge
//   i_reset : synchronous active-high reset, clears every memory word
//   bus     : slave side of exec_mem_stage_if (operands in, control and
//             datapath results out)
// ----------------------------------------------------------------------------
module exec_mem_stage
  import exec_mem_stage_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  exec_mem_stage_if.slave  bus
);

  ctrl_t             w_ctrl;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_result;
  logic [DATA_W-1:0] w_read_data;

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  // Opcode to control decode; unknown opcodes write nothing anywhere
  always_comb begin
    w_ctrl = make_ctrl(ALU_ZERO, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    case (bus.opcode)
      OP_ADD:  w_ctrl = make_ctrl(ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_SUB:  w_ctrl = make_ctrl(ALU_SUB,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_AND:  w_ctrl = make_ctrl(ALU_AND,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_OR:   w_ctrl = make_ctrl(ALU_OR,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_ADDI: w_ctrl = make_ctrl(ALU_ADD,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      OP_LW:   w_ctrl = make_ctrl(ALU_ADD,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      OP_SW:   w_ctrl = make_ctrl(ALU_ADD,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      OP_J:    w_ctrl = make_ctrl(ALU_ZERO, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      default: w_ctrl = make_ctrl(ALU_ZERO, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endcase
  end

  // ALU B operand: register or immediate
  always_comb begin
    if (w_ctrl.alu_src) begin
      w_alu_b = bus.imm_ext;
    end else begin
      w_alu_b = bus.rt_data;
    end
  end

  alu_core u_alu (
    .i_alu_op (w_ctrl.alu_op),
    .i_a      (bus.rs_data),
    .i_b      (w_alu_b),
    .o_result (w_alu_result)
  );

  // Asynchronous read: old word is visible until the write edge
  assign w_read_data = r_mem[w_alu_result[ADDR_W-1:0]];

  // Data memory: reset clears all words and overrides a same-edge store
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (w_ctrl.mem_write) begin
      r_mem[w_alu_result[ADDR_W-1:0]] <= bus.rt_data;
    end
  end

  assign bus.jump       = w_ctrl.jump;
  assign bus.reg_write  = w_ctrl.reg_write;
  assign bus.mem_write  = w_ctrl.mem_write;
  assign bus.alu_src    = w_ctrl.alu_src;
  assign bus.wb_sel     = w_ctrl.wb_sel;
  assign bus.alu_op     = w_ctrl.alu_op;
  assign bus.alu_result = w_alu_result;
  assign bus.read_data  = w_read_data;
  assign bus.writeback  = w_ctrl.wb_sel ? w_alu_result : w_read_data;

endmodule

// File: tb/tb_exec_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_exec_mem_stage
// Directed steps followed by random instructions; every output is compared
// against a behavioural model of the instruction set and a 256-entry memory.
// ----------------------------------------------------------------------------
module tb_exec_mem_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [7:0] model_mem [256];

  exec_mem_stage_if bus ();

  exec_mem_stage u_dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Expected {jump, mem_write, alu_src, wb_sel, reg_write} per instruction
  function automatic logic [4:0] exp_ctrl(input logic [2:0] op);
    case (op)
      3'd4:    return 5'b00111;  // ADDI
      3'd5:    return 5'b00101;  // LW
      3'd6:    return 5'b01110;  // SW
      3'd7:    return 5'b10010;  // J
      default: return 5'b00011;  // register ALU ops
    endcase
  endfunction

  function automatic logic [7:0] exp_result(input logic [2:0] op, input logic [7:0] rs,
                                            input logic [7:0] rt, input logic [7:0] imm);
    int r;
    case (op)
      3'd0:    r = int'(rs) + int'(rt);
      3'd1:    r = int'(rs) - int'(rt) + 256;
      3'd2:    r = int'(rs & rt);
      3'd3:    r = int'(rs | rt);
      3'd7:    r = 0;
      default: r = int'(rs) + int'(imm);
    endcase
    return 8'(r % 256);
  endfunction

  // One instruction: drive on the falling edge, check, then let the edge pass
  task automatic step(input logic [2:0] op, input logic [7:0] rs, input logic [7:0] rt,
                      input logic [7:0] imm, input logic rst_in, input string tag);
    logic [7:0] e_res;
    logic [7:0] e_rd;
    logic [7:0] e_wb;
    logic [4:0] e_c;
    logic [2:0] e_aop;
    @(negedge clk);
    bus.opcode  = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    bus.imm_ext = imm;
    rst         = rst_in;
    #1;
    e_res = exp_result(op, rs, rt, imm);
    e_rd  = model_mem[e_res];
    e_c   = exp_ctrl(op);
    e_wb  = (op == 3'd5) ? e_rd : e_res;
    e_aop = (op <= 3'd3) ? op : ((op == 3'd7) ? 3'd7 : 3'd0);
    chk({tag, "_result"}, bus.alu_result, e_res);
    chk({tag, "_rdata"}, bus.read_data, e_rd);
    chk({tag, "_wb"}, bus.writeback, e_wb);
    chk({tag, "_ctrl"}, {3'b000, bus.jump, bus.mem_write, bus.alu_src, bus.wb_sel, bus.reg_write},
        {3'b000, e_c});
    chk({tag, "_aluop"}, {5'b00000, bus.alu_op}, {5'b00000, e_aop});
    @(posedge clk);
    if (rst_in) begin
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    end else if (op == 3'd6) begin
      model_mem[e_res] = rt;
    end
  endtask

  initial begin
    logic [2:0] r_op;
    logic [2:0] r_imm3;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.opcode  = 3'b111;
    bus.rs_data = 8'h00;
    bus.rt_data = 8'h00;
    bus.imm_ext = 8'h00;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    repeat (2) @(posedge clk);

    // Load from cleared memory
    step(3'd5, 8'h10, 8'h00, 8'h00, 1'b0, "lw_after_reset");
    chk("lw_after_reset_lit", bus.writeback, 8'h00);
    // Store then load back through the same address
    step(3'd6, 8'h05, 8'hA5, 8'h02, 1'b0, "sw_07");
    step(3'd5, 8'h05, 8'h00, 8'h02, 1'b0, "lw_07");
    chk("lw_07_lit", bus.writeback, 8'hA5);
    // Register ALU ops
    step(3'd0, 8'h0C, 8'h0A, 8'h00, 1'b0, "add");
    chk("add_lit", bus.alu_result, 8'h16);
    step(3'd1, 8'h0C, 8'h0A, 8'h00, 1'b0, "sub");
    step(3'd2, 8'h0C, 8'h0A, 8'h00, 1'b0, "and");
    step(3'd3, 8'h0C, 8'h0A, 8'h00, 1'b0, "or");
    chk("or_lit", bus.alu_result, 8'h0E);
    // Wrap-around cases
    step(3'd4, 8'hFF, 8'h00, 8'h01, 1'b0, "addi_wrap");
    step(3'd1, 8'h00, 8'h01, 8'h00, 1'b0, "sub_wrap");
    step(3'd4, 8'h03, 8'h00, 8'hFC, 1'b0, "addi_neg");
    // Jump changes nothing in memory
    step(3'd7, 8'h55, 8'h66, 8'h01, 1'b0, "jump");
    step(3'd5, 8'h07, 8'h00, 8'h00, 1'b0, "lw_after_jump");
    // Reset beats a simultaneous store
    step(3'd6, 8'h20, 8'h77, 8'h00, 1'b0, "sw_20");
    step(3'd6, 8'h20, 8'h3C, 8'h00, 1'b1, "sw_with_reset");
    step(3'd5, 8'h20, 8'h00, 8'h00, 1'b0, "lw_20_cleared");
    chk("lw_20_lit", bus.read_data, 8'h00);
    step(3'd5, 8'h07, 8'h00, 8'h00, 1'b0, "lw_07_cleared");

    // Random instruction stream with rare resets
    for (int n = 0; n < 400; n++) begin
      r_op   = 3'($urandom_range(0, 7));
      r_imm3 = 3'($urandom_range(0, 7));
      step(r_op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           {{5{r_imm3[2]}}, r_imm3}, ($urandom_range(0, 63) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
